// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, keypad map, FSM state and frame-result types
// for the keypad controller.
package keypad_pkg;

    // Non-digit key codes
    localparam logic [3:0] KEY_A   = 4'hA;
    localparam logic [3:0] KEY_B   = 4'hB;
    localparam logic [3:0] KEY_C   = 4'hC;
    localparam logic [3:0] KEY_D   = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_BS  = 4'hF;

    // Auto-repeat timing in frames (used only with KEYPAD_REPEAT_EN)
    localparam int unsigned REPEAT_FIRST_FRAMES = 500;
    localparam int unsigned REPEAT_NEXT_FRAMES  = 100;

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StReleaseDb
    } kp_state_e;

    typedef enum logic [1:0] {
        FrNone,
        FrKey,
        FrMulti
    } frame_kind_e;

    // Physical (row, col) position to key code
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        unique case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = KEY_A;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = KEY_B;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_CLR;
            4'hD: code = 4'h0;
            4'hE: code = KEY_BS;
            4'hF: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: row synchronizer, column drive and per-frame scan result.
// Rows are sampled on the last cycle of each column window; after column 3 the
// frame result (none / single key / multiple keys) is presented for one cycle.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  KEY_ROW,
    output logic [3:0]  KEY_COL,
    output logic        frame_done,
    output frame_kind_e frame_kind,
    output logic [3:0]  frame_code
);

    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       hits_q, hits_d;
    logic [3:0]       code_q, code_d;

    logic             window_end;
    logic [3:0]       row_low;
    logic [2:0]       col_hits;
    logic [2:0]       tot_hits;
    logic [1:0]       row_idx;
    logic [1:0]       frame_hits;
    logic [3:0]       frame_code_c;

    // Two-flop synchronizer on the asynchronous row inputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= KEY_ROW;
            row_sync_q <= row_meta_q;
        end
    end

    // Scan divider, column counter and in-frame hit accumulator
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q  <= '0;
            col_q  <= 2'd0;
            hits_q <= 2'd0;
            code_q <= 4'd0;
        end else begin
            div_q  <= div_d;
            col_q  <= col_d;
            hits_q <= hits_d;
            code_q <= code_d;
        end
    end

    // Per-window sampling; hit count saturates at 2 (anything above one is MULTI)
    always_comb begin
        window_end = (div_q == DIV_LAST);
        row_low    = ~row_sync_q;
        col_hits   = {2'b00, row_low[0]} + {2'b00, row_low[1]} +
                     {2'b00, row_low[2]} + {2'b00, row_low[3]};
        row_idx    = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) row_idx = 2'(r);
        end
        tot_hits     = {1'b0, hits_q} + col_hits;
        frame_hits   = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
        frame_code_c = (hits_q == 2'd0 && col_hits == 3'd1) ? key_map(row_idx, col_q) : code_q;

        div_d  = window_end ? '0 : div_q + DIV_W'(1);
        col_d  = window_end ? col_q + 2'd1 : col_q;
        hits_d = hits_q;
        code_d = code_q;
        if (window_end) begin
            if (col_q == 2'd3) begin
                hits_d = 2'd0;
                code_d = 4'd0;
            end else begin
                hits_d = frame_hits;
                code_d = frame_code_c;
            end
        end
    end

    assign KEY_COL    = ~(4'b0001 << col_q);
    assign frame_done = window_end && (col_q == 2'd3);
    assign frame_kind = (frame_hits == 2'd0) ? FrNone :
                        (frame_hits == 2'd1) ? FrKey : FrMulti;
    assign frame_code = frame_code_c;

endmodule

// File: rtl/keypad_controller.sv
// keypad_controller: 4x4 matrix keypad front end. Debounces whole scan frames,
// emits one-cycle key events and keeps an 8-digit BCD entry register whose
// packing matches the display NUM input.
// Optional: define KEYPAD_REPEAT_EN for auto-repeat while a key stays held.
module keypad_controller
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned NUM_DIGITS   = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  KEY_ROW,
    output logic [3:0]  KEY_COL,
    output logic        KEY_VALID,
    output logic [3:0]  KEY_CODE,
    output logic [33:0] NUM,
    output logic [3:0]  DIGIT_CNT
);

    localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CNT);
    localparam logic [3:0] DIGIT_MAX = 4'(NUM_DIGITS);

    logic        frame_done;
    frame_kind_e frame_kind;
    logic [3:0]  frame_code;

    kp_state_e   state_q, state_d;
    logic [3:0]  db_cnt_q, db_cnt_d, cnt_inc;
    logic [3:0]  cand_q, cand_d;
    logic        accept;

    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic [31:0] num_q, num_d;
    logic [3:0]  digit_cnt_q, digit_cnt_d;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [8:0] REP_FIRST_LAST = 9'(REPEAT_FIRST_FRAMES - 1);
    localparam logic [8:0] REP_NEXT_LAST  = 9'(REPEAT_NEXT_FRAMES - 1);
    logic [8:0] rep_cnt_q, rep_cnt_d, rep_last;
    logic       rep_fast_q, rep_fast_d;
`endif

    keypad_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .KEY_ROW    (KEY_ROW),
        .KEY_COL    (KEY_COL),
        .frame_done (frame_done),
        .frame_kind (frame_kind),
        .frame_code (frame_code)
    );

    assign cnt_inc = db_cnt_q + 4'd1;

    // FSM state register: state, debounce count and candidate key
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            db_cnt_q   <= 4'd0;
            cand_q     <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q  <= 9'd0;
            rep_fast_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            cand_q     <= cand_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
            rep_fast_q <= rep_fast_d;
`endif
        end
    end

    // FSM next state; evaluated only when a frame result is presented
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        cand_d   = cand_q;
        accept   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        rep_fast_d = rep_fast_q;
        rep_last   = rep_fast_q ? REP_NEXT_LAST : REP_FIRST_LAST;
`endif
        if (frame_done) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_kind == FrKey) begin
                        cand_d   = frame_code;
                        db_cnt_d = 4'd1;
                        if (DB_LAST == 4'd1) begin
                            accept  = 1'b1;
                            state_d = StHeld;
                        end else begin
                            state_d = StPressDb;
                        end
                    end
                end
                StPressDb: begin
                    if (frame_kind == FrKey) begin
                        if (frame_code == cand_q) begin
                            db_cnt_d = cnt_inc;
                            if (cnt_inc >= DB_LAST) begin
                                accept  = 1'b1;
                                state_d = StHeld;
                            end
                        end else begin
                            cand_d   = frame_code;
                            db_cnt_d = 4'd1;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    // MULTI or any key keeps the hold; only a clear frame starts release
                    if (frame_kind == FrNone) begin
                        db_cnt_d = 4'd1;
                        state_d  = (DB_LAST == 4'd1) ? StIdle : StReleaseDb;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (frame_kind == FrKey && frame_code == cand_q) begin
                        if (rep_cnt_q == rep_last) begin
                            accept     = 1'b1;
                            rep_cnt_d  = 9'd0;
                            rep_fast_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 9'd1;
                        end
                    end else begin
                        rep_cnt_d  = 9'd0;
                        rep_fast_d = 1'b0;
                    end
`endif
                end
                StReleaseDb: begin
                    if (frame_kind == FrNone) begin
                        db_cnt_d = cnt_inc;
                        if (cnt_inc >= DB_LAST) state_d = StIdle;
                    end else begin
                        state_d = StHeld;
                    end
                end
            endcase
`ifdef KEYPAD_REPEAT_EN
            if (state_q != StHeld) begin
                rep_cnt_d  = 9'd0;
                rep_fast_d = 1'b0;
            end
`endif
        end
    end

    // Accept action: event pulse, last code and entry-register edit
    always_comb begin
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        num_d       = num_q;
        digit_cnt_d = digit_cnt_q;
        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = cand_d;
            unique case (cand_d)
                KEY_CLR: begin
                    num_d       = 32'd0;
                    digit_cnt_d = 4'd0;
                end
                KEY_BS: begin
                    if (digit_cnt_q != 4'd0) begin
                        num_d       = {4'h0, num_q[31:4]};
                        digit_cnt_d = digit_cnt_q - 4'd1;
                    end
                end
                KEY_A, KEY_B, KEY_C, KEY_D: begin
                end
                default: begin
                    if (digit_cnt_q < DIGIT_MAX) begin
                        num_d       = {num_q[27:0], cand_d};
                        digit_cnt_d = digit_cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    // Output and entry registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            num_q       <= 32'd0;
            digit_cnt_q <= 4'd0;
        end else begin
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            num_q       <= num_d;
            digit_cnt_q <= digit_cnt_d;
        end
    end

    assign KEY_VALID = key_valid_q;
    assign KEY_CODE  = key_code_q;
    assign NUM       = {2'b00, num_q};
    assign DIGIT_CNT = digit_cnt_q;

endmodule

// File: tb/tb_keypad_controller.sv
// tb_keypad_controller: directed and random keypad stimulus against a
// frame-level reference model (SCAN_DIV=4, DEBOUNCE_CNT=2, 16-cycle frames).
module tb_keypad_controller;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DB       = 2;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  KEY_ROW;
    logic [3:0]  KEY_COL;
    logic        KEY_VALID;
    logic [3:0]  KEY_CODE;
    logic [33:0] NUM;
    logic [3:0]  DIGIT_CNT;

    logic [15:0] pressed = 16'h0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;

    // Key legend indexed by row*4+col
    int key_table [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // Reference model state
    int   digits [$];
    int   m_code;
    bit   m_released;
    int   m_run_len, m_run_code, m_none_run;
    bit   pending;
    int   pending_code;

    keypad_controller #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DB),
        .NUM_DIGITS   (8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .KEY_ROW   (KEY_ROW),
        .KEY_COL   (KEY_COL),
        .KEY_VALID (KEY_VALID),
        .KEY_CODE  (KEY_CODE),
        .NUM       (NUM),
        .DIGIT_CNT (DIGIT_CNT)
    );

    always #5 CLK = ~CLK;

    // Ideal switch matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        KEY_ROW = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !KEY_COL[c]) KEY_ROW[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input int code);
        int idx = 0;
        for (int i = 0; i < 16; i++) if (key_table[i] == code) idx = i;
        return idx;
    endfunction

    function automatic logic [33:0] model_num();
        logic [33:0] n = '0;
        foreach (digits[i]) n = (n << 4) | 34'(digits[i]);
        return n;
    endfunction

    task automatic model_reset();
        digits.delete();
        m_code     = 0;
        m_released = 1'b1;
        m_run_len  = 0;
        m_run_code = 0;
        m_none_run = 0;
        pending    = 1'b0;
    endtask

    task automatic model_apply(input int code);
        m_code = code;
        if (code <= 9) begin
            if (digits.size() < 8) digits.push_back(code);
        end else if (code == 14) begin
            digits.delete();
        end else if (code == 15) begin
            if (digits.size() > 0) void'(digits.pop_back());
        end
    endtask

    // A key is accepted after DB consecutive single-key frames of the same code,
    // provided DB consecutive empty frames were seen since the previous accept.
    task automatic model_frame(input logic [15:0] mask);
        int n;
        int code;
        n       = $countones(mask);
        pending = 1'b0;
        if (n == 0) begin
            m_none_run++;
            m_run_len = 0;
            if (m_none_run >= DB) m_released = 1'b1;
        end else if (n > 1) begin
            m_none_run = 0;
            m_run_len  = 0;
        end else begin
            code = 0;
            for (int i = 0; i < 16; i++) if (mask[i]) code = key_table[i];
            m_none_run = 0;
            if (m_run_len > 0 && code == m_run_code) m_run_len++;
            else begin
                m_run_code = code;
                m_run_len  = 1;
            end
            if (m_released && m_run_len >= DB) begin
                pending      = 1'b1;
                pending_code = code;
                m_released   = 1'b0;
            end
        end
    endtask

    task automatic check_regs();
        chk("key_code", 34'(KEY_CODE), 34'(m_code));
        chk("num", NUM, model_num());
        chk("digit_cnt", 34'(DIGIT_CNT), 34'(digits.size()));
    endtask

    // Entered and left at the negedge of cycle 0 of a frame
    task automatic do_frame(input logic [15:0] mask);
        logic [3:0] col_exp;
        if (pending) model_apply(pending_code);
        if (KEY_VALID === 1'b1) pulses++;
        chk("key_valid_event", 34'(KEY_VALID), 34'(pending));
        check_regs();
        chk("key_col", 34'(KEY_COL), 34'(4'b1110));
        pressed = mask;
        model_frame(mask);
        for (int i = 1; i < int'(FRAME); i++) begin
            @(posedge CLK);
            @(negedge CLK);
            col_exp = ~(4'b0001 << (i / int'(SCAN_DIV)));
            chk("key_valid_quiet", 34'(KEY_VALID), 34'd0);
            chk("key_col", 34'(KEY_COL), 34'(col_exp));
            check_regs();
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic press_key(input int code, input int frames);
        logic [15:0] m;
        m = 16'(1) << idx_of(code);
        repeat (frames) do_frame(m);
        do_frame(16'h0);
        do_frame(16'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col"}, 34'(KEY_COL), 34'(4'b1110));
        chk({tag, "_valid"}, 34'(KEY_VALID), 34'd0);
        chk({tag, "_code"}, 34'(KEY_CODE), 34'd0);
        chk({tag, "_num"}, NUM, 34'd0);
        chk({tag, "_cnt"}, 34'(DIGIT_CNT), 34'd0);
    endtask

    initial begin
        int p0;
        int sel, hold, a, b;
        logic [15:0] m;

        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("reset");
        RST_N = 1'b1;

        // Column walk and quiet outputs with nothing pressed
        do_frame(16'h0);
        do_frame(16'h0);

        // Clean press of "5" for three frames, then re-press after release
        p0 = pulses;
        repeat (3) do_frame(16'(1) << 5);
        do_frame(16'h0);
        do_frame(16'h0);
        chk("clean_pulses", 34'(pulses - p0), 34'd1);
        chk("clean_code", 34'(KEY_CODE), 34'h5);
        chk("clean_num", NUM, 34'h5);
        chk("clean_cnt", 34'(DIGIT_CNT), 34'd1);
        press_key(5, 2);
        chk("repress_num", NUM, 34'h55);

        // Bouncing "7" never reaches two consecutive frames
        p0 = pulses;
        do_frame(16'(1) << 8);
        do_frame(16'h0);
        do_frame(16'(1) << 8);
        do_frame(16'h0);
        do_frame(16'h0);
        chk("bounce_pulses", 34'(pulses - p0), 34'd0);

        // Entry: clear, 1..9 (ninth ignored), backspace, clear
        press_key(14, 2);
        chk("clr_num", NUM, 34'h0);
        for (int d = 1; d <= 9; d++) press_key(d, 2);
        chk("entry_num", NUM, 34'h12345678);
        chk("entry_cnt", 34'(DIGIT_CNT), 34'd8);
        chk("entry_code", 34'(KEY_CODE), 34'h9);
        press_key(15, 2);
        chk("bs_num", NUM, 34'h01234567);
        chk("bs_cnt", 34'(DIGIT_CNT), 34'd7);
        press_key(14, 2);
        chk("clr2_num", NUM, 34'h0);
        chk("clr2_cnt", 34'(DIGIT_CNT), 34'd0);

        // Multi-key "1"+"2", then "2" released
        p0 = pulses;
        repeat (4) do_frame(16'h0003);
        chk("multi_pulses", 34'(pulses - p0), 34'd0);
        press_key(1, 2);
        chk("multi_rel_pulses", 34'(pulses - p0), 34'd1);
        chk("multi_rel_code", 34'(KEY_CODE), 34'h1);
        chk("multi_rel_num", NUM, 34'h1);

        // Asynchronous reset one frame into debouncing "3"
        do_frame(16'(1) << 2);
        chk("pre_rst_valid", 34'(KEY_VALID), 34'd0);
        RST_N = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("async_rst_hold");
        RST_N = 1'b1;
        model_reset();
        p0 = pulses;
        do_frame(16'(1) << 2);
        do_frame(16'(1) << 2);
        do_frame(16'h0);
        do_frame(16'h0);
        chk("post_rst_pulses", 34'(pulses - p0), 34'd1);
        chk("post_rst_code", 34'(KEY_CODE), 34'h3);
        chk("post_rst_num", NUM, 34'h3);

        // Random key activity against the model
        repeat (70) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                m = 16'h0;
            end else if (sel < 8) begin
                m = 16'(1) << $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                m = (16'(1) << a) | (16'(1) << b);
            end
            hold = $urandom_range(1, 3);
            repeat (hold) do_frame(m);
        end
        do_frame(16'h0);
        do_frame(16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
